// File: rtl/spi_reg_ctrl.sv
// Two-frame command/register controller sitting on the parallel side of the SPI
// slave shifter: a command frame (R/W + address) is followed by one data frame.
module spi_reg_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          drv_ready,
    input  logic [DATA_WIDTH-1:0]         drv_data_out,
    output logic [DATA_WIDTH-1:0]         drv_data_in,
    input  logic [7:0]                    ro_status,
    output logic [(2**ADDR_WIDTH)*8-1:0]  regs_flat,
    output logic                          wr_strobe,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic                          err,
    output logic [1:0]                    state_dbg
);
    localparam int NREG = 2**ADDR_WIDTH;
    localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] RSV_MASK = 8'h7f & ~8'((1 << ADDR_WIDTH) - 1);

    typedef enum logic [1:0] {S_CMD = 2'd0, S_DATA = 2'd1, S_SKIP = 2'd2} state_t;

    state_t                state, state_nxt;
    logic                  ready_q;
    logic                  frame_end;
    logic [7:0]            rx_byte;
    logic [ADDR_WIDTH-1:0] rx_addr;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            rd_data;
    logic [7:0]            tx_byte;
    logic [CW-1:0]         tmo_cnt;
    logic                  tmo_hit;
    logic                  cmd_latch, do_write, err_set, err_clr;
    logic [7:0]            bank [NREG];
    logic [DATA_WIDTH-9:0] unused_hi;

    // Handshake: drv_ready high means the shifter is idle; its rising edge marks a
    // completed frame whose byte sits in drv_data_out[7:0], and its falling edge is
    // the instant the shifter samples drv_data_in. Nothing else is exchanged.
    assign frame_end = drv_ready & ~ready_q;
    assign rx_byte   = drv_data_out[7:0];
    assign rx_addr   = rx_byte[ADDR_WIDTH-1:0];
    assign unused_hi = drv_data_out[DATA_WIDTH-1:8];
    assign tmo_hit   = (tmo_cnt == CW'(TIMEOUT_CYCLES));
    assign state_dbg = state;

    assign drv_data_in = {{(DATA_WIDTH-8){1'b0}}, tx_byte};

    always_comb begin
        regs_flat = '0;
        for (int i = 1; i < NREG; i++) regs_flat[i*8 +: 8] = bank[i];
    end

    always_comb begin
        state_nxt = state;
        tx_byte   = 8'h00;
        cmd_latch = 1'b0;
        do_write  = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        case (state)
            S_CMD: begin
                tx_byte = {err, 7'h25};
                if (frame_end) begin
                    cmd_latch = 1'b1;
                    if (|(rx_byte & RSV_MASK)) begin
                        err_set   = 1'b1;
                        state_nxt = S_SKIP;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                tx_byte = cmd_wr ? 8'h00 : rd_data;
                // A frame completing on the expiry cycle still gets processed.
                if (frame_end) begin
                    state_nxt = S_CMD;
                    if (cmd_wr) begin
                        if (cmd_addr != '0) do_write = 1'b1;
                        else                err_set  = 1'b1;
                    end else if (cmd_addr == '0) begin
                        err_clr = 1'b1;
                    end
                end else if (tmo_hit) begin
                    err_set   = 1'b1;
                    state_nxt = S_CMD;
                end
            end
            S_SKIP: begin
                if (frame_end) begin
                    state_nxt = S_CMD;
                end else if (tmo_hit) begin
                    err_set   = 1'b1;
                    state_nxt = S_CMD;
                end
            end
            default: state_nxt = S_CMD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_CMD;
            ready_q   <= 1'b1;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            rd_data   <= 8'h00;
            tmo_cnt   <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            err       <= 1'b0;
            for (int i = 0; i < NREG; i++) bank[i] <= 8'h00;
        end else begin
            state     <= state_nxt;
            ready_q   <= drv_ready;
            wr_strobe <= do_write;
            if (cmd_latch) begin
                cmd_wr   <= rx_byte[7];
                cmd_addr <= rx_addr;
                // Read data is frozen here so it stays stable for the whole data frame.
                rd_data  <= (rx_addr == '0) ? ro_status : bank[rx_addr];
            end
            if (do_write) begin
                bank[cmd_addr] <= rx_byte;
                wr_addr        <= cmd_addr;
            end
            if (state == S_CMD)  tmo_cnt <= '0;
            else if (drv_ready)  tmo_cnt <= tmo_cnt + CW'(1);
            if (err_set)         err <= 1'b1;
            else if (err_clr)    err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed vector table, timeout and reset sequences, then
// randomized transactions checked against a transaction-level register model.
module tb_spi_reg_ctrl;
    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int TMO = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            drv_ready = 1'b1;
    logic [DW-1:0]   drv_data_out = '0;
    logic [DW-1:0]   drv_data_in;
    logic [7:0]      ro_status = 8'h00;
    logic [127:0]    regs_flat;
    logic            wr_strobe;
    logic [AW-1:0]   wr_addr;
    logic            err;
    logic [1:0]      state_dbg;

    spi_reg_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .drv_ready(drv_ready), .drv_data_out(drv_data_out),
        .drv_data_in(drv_data_in), .ro_status(ro_status), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_cnt = 0;

    // Reference model: register bank as a byte array plus the sticky error bit.
    logic [7:0]  m_regs [16];
    logic        m_err;
    logic [11:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        f = '0;
        for (int i = 1; i < 16; i++) f[i*8 +: 8] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_txn(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] ro,
                             output logic [7:0] exp1, output logic [7:0] exp2);
        int a;
        a = int'(cmd) % 16;
        exp1 = {m_err, 7'h25};
        exp2 = 8'h00;
        if ((int'(cmd) / 16) % 8 != 0) begin
            m_err = 1'b1;
        end else if (cmd >= 8'h80) begin
            if (a == 0) m_err = 1'b1;
            else begin
                m_regs[a] = data;
                exp_q.push_back({4'(a), data});
            end
        end else begin
            exp2 = (a == 0) ? ro : m_regs[a];
            if (a == 0) m_err = 1'b0;
        end
    endtask

    // One chip-select frame, entered and left on a negedge.
    task automatic do_frame(input logic [7:0] mosi, input int len, input int gap,
                            output logic [DW-1:0] miso);
        logic [31:0] r;
        miso = drv_data_in;
        drv_ready = 1'b0;
        repeat (len) @(negedge clk);
        r = $urandom();
        drv_data_out = {r[31:8], mosi};
        drv_ready = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] ro,
                           output logic [DW-1:0] got1, output logic [DW-1:0] got2);
        ro_status = ro;
        do_frame(cmd,  $urandom_range(2, 9), $urandom_range(4, 10), got1);
        do_frame(data, $urandom_range(2, 9), $urandom_range(4, 10), got2);
    endtask

    task automatic txn_check(input string tag, input logic [7:0] cmd, input logic [7:0] data,
                             input logic [7:0] ro);
        logic [7:0]    e1, e2;
        logic [DW-1:0] g1, g2;
        model_txn(cmd, data, ro, e1, e2);
        run_txn(cmd, data, ro, g1, g2);
        check({tag, "_miso_cmd"},  g1, e1);
        check({tag, "_miso_data"}, g2, e2);
        check({tag, "_err"}, err, m_err);
        check({tag, "_regs"}, regs_flat, model_flat());
        check({tag, "_strobe_pending"}, exp_q.size(), 0);
    endtask

    // Scoreboard: every wr_strobe cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            strobe_cnt++;
            if (exp_q.size() == 0) check("wr_strobe_extra", 1, 0);
            else check("wr_strobe", {wr_addr, regs_flat[wr_addr*8 +: 8]}, exp_q.pop_front());
        end
    end

    typedef struct {
        logic [7:0] cmd, data, ro, miso1, miso2;
        logic       err;
        int         strobes;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [7:0]    e1, e2;
        logic [DW-1:0] g1, g2;
        int            sc0;

        tbl[0]  = '{8'h83, 8'h5C, 8'h00, 8'h25, 8'h00, 1'b0, 1};
        tbl[1]  = '{8'h03, 8'h00, 8'h00, 8'h25, 8'h5C, 1'b0, 0};
        tbl[2]  = '{8'h00, 8'h00, 8'hA7, 8'h25, 8'hA7, 1'b0, 0};
        tbl[3]  = '{8'h90, 8'hFF, 8'h00, 8'h25, 8'h00, 1'b1, 0};
        tbl[4]  = '{8'h03, 8'h00, 8'h00, 8'hA5, 8'h5C, 1'b1, 0};
        tbl[5]  = '{8'h00, 8'h00, 8'h3C, 8'hA5, 8'h3C, 1'b0, 0};
        tbl[6]  = '{8'h80, 8'h11, 8'h00, 8'h25, 8'h00, 1'b1, 0};
        tbl[7]  = '{8'h00, 8'h00, 8'h01, 8'hA5, 8'h01, 1'b0, 0};
        tbl[8]  = '{8'h8F, 8'hE1, 8'h00, 8'h25, 8'h00, 1'b0, 1};
        tbl[9]  = '{8'h0F, 8'h00, 8'h00, 8'h25, 8'hE1, 1'b0, 0};
        tbl[10] = '{8'h70, 8'hAA, 8'h00, 8'h25, 8'h00, 1'b1, 0};
        tbl[11] = '{8'h00, 8'h00, 8'h55, 8'hA5, 8'h55, 1'b0, 0};

        // Clock/reset: reset must act before any clock edge.
        model_reset();
        #1 rst = 1'b1;
        #2;
        check("rst_drv_data_in", drv_data_in, 32'h25);
        check("rst_regs", regs_flat, 0);
        check("rst_err", err, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_state", state_dbg, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            sc0 = strobe_cnt;
            model_txn(tbl[i].cmd, tbl[i].data, tbl[i].ro, e1, e2);
            run_txn(tbl[i].cmd, tbl[i].data, tbl[i].ro, g1, g2);
            check($sformatf("vec%0d_miso_cmd", i),  g1, tbl[i].miso1);
            check($sformatf("vec%0d_miso_data", i), g2, tbl[i].miso2);
            check($sformatf("vec%0d_err", i), err, tbl[i].err);
            check($sformatf("vec%0d_strobes", i), strobe_cnt - sc0, tbl[i].strobes);
            check($sformatf("vec%0d_model_miso", i), g2, e2);
            check($sformatf("vec%0d_regs", i), regs_flat, model_flat());
            if (i == 0) begin
                check("vec0_wr_addr", wr_addr, 3);
                check("vec0_reg3", regs_flat[31:24], 8'h5C);
            end
            if (i == 6) check("vec6_reg0", regs_flat[7:0], 0);
        end

        // Timeout: command 0x85 then cs held high well past the limit.
        do_frame(8'h85, 6, 18, g1);
        check("tmo_err_before", err, 0);
        check("tmo_state_before", state_dbg, 1);
        repeat (7) @(negedge clk);
        check("tmo_err_after", err, 1);
        check("tmo_state_after", state_dbg, 0);
        check("tmo_regs", regs_flat, model_flat());
        m_err = 1'b1;
        txn_check("tmo_next_cmd", 8'h12, 8'h77, 8'h00);
        txn_check("tmo_clear", 8'h00, 8'h00, 8'h5A);

        // Async reset in the middle of a data frame, with err set and regs 1/2 written.
        txn_check("pre_rst_w0", 8'h80, 8'h11, 8'h00);
        txn_check("pre_rst_w1", 8'h81, 8'hA1, 8'h00);
        txn_check("pre_rst_w2", 8'h82, 8'hB2, 8'h00);
        do_frame(8'h81, 5, 5, g1);
        drv_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_drv_data_in", drv_data_in, 32'h25);
        check("mid_rst_regs", regs_flat, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_wr_strobe", wr_strobe, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_state", state_dbg, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // The interrupted frame completes after reset and counts as a command byte.
        model_txn(8'h84, 8'h44, 8'h00, e1, e2);
        drv_data_out = {24'h0, 8'h84};
        repeat (2) @(negedge clk);
        drv_ready = 1'b1;
        repeat (5) @(negedge clk);
        do_frame(8'h44, 4, 6, g2);
        check("post_rst_tail_miso", g2, e2);
        check("post_rst_tail_regs", regs_flat, model_flat());
        check("post_rst_tail_strobe", exp_q.size(), 0);
        txn_check("post_rst_w1", 8'h81, 8'h33, 8'h00);
        txn_check("post_rst_r1", 8'h01, 8'h00, 8'h00);
        txn_check("post_rst_r4", 8'h04, 8'h00, 8'h00);
        txn_check("post_rst_r2", 8'h02, 8'h00, 8'h00);

        // Randomized transactions against the model.
        for (int n = 0; n < 120; n++) begin
            logic [7:0] cmd, data, ro;
            cmd  = {1'($urandom_range(0, 1)), 3'b000, 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 7) == 0) cmd[6:4] = 3'($urandom_range(1, 7));
            data = 8'($urandom_range(0, 255));
            ro   = 8'($urandom_range(0, 255));
            txn_check($sformatf("rnd%0d", n), cmd, data, ro);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command/register controller behind the byte-framed SPI slave shifter (`spi_slave_driver`).
- Each chip-select frame carries one byte.
- A two-frame protocol runs on top of that:
  - Frame 1 is a command byte: R/W flag plus address.
  - Frame 2 is a data byte: write data from the master, or read data returned to the master.
- Sequences the shifter's parallel interface, owns a 2**ADDR_WIDTH x 8 register bank, and exports it to the core.

Parameters:
- DATA_WIDTH, 32: width of the shifter's parallel data bus; only bits [7:0] are meaningful.
- ADDR_WIDTH, 4: register address width; bank holds 2**ADDR_WIDTH 8-bit registers.
- TIMEOUT_CYCLES, 65535: max clk cycles allowed between command-frame end and data-frame start.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- drv_ready  in  1  shifter idle flag (high = no frame in progress).
- drv_data_out  in  DATA_WIDTH  shifter capture register; byte received in the last frame is in [7:0].
- drv_data_in  out  DATA_WIDTH  byte the shifter loads at frame start (in [7:0]); upper bits are 0.
- ro_status  in  8  core status, readable at address 0.
- regs_flat  out  (2**ADDR_WIDTH)*8  register bank, register n at [8n+7:8n]; slot 0 is always 0.
- wr_strobe  out  1  one-cycle pulse when a register is written.
- wr_addr  out  ADDR_WIDTH  address of the last write; valid with wr_strobe.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Frame detection:
  - ready_q = drv_ready delayed one clk; reset value 1.
  - frame_end = drv_ready & ~ready_q.
  - frame_start = ~drv_ready & ready_q.
- Command byte format (bits [7:0] of drv_data_out):
  - bit7 = 1 means write, 0 means read.
  - bits[6:ADDR_WIDTH] are reserved and must be 0.
  - bits[ADDR_WIDTH-1:0] are the address.
- States and transitions:
  - S_CMD:
    - drv_data_in[7:0] = {err, 7'h25}.
    - On frame_end, latch cmd byte.
    - If reserved bits are nonzero: set err, go to S_SKIP.
    - Otherwise go to S_DATA.
  - S_DATA, read command:
    - drv_data_in[7:0] = addr==0 ? ro_status : reg[addr].
    - The value is registered on the S_CMD->S_DATA transition and held stable for the whole frame.
  - S_DATA, write command:
    - drv_data_in[7:0] = 8'h00.
  - S_DATA, on frame_end:
    - Write with addr != 0: reg[addr] <= drv_data_out[7:0]; wr_strobe = 1 for one cycle (same edge); wr_addr <= addr.
    - Write to addr 0: discarded, err set, no wr_strobe.
    - Read of addr 0: clears err.
    - Read of any other address: no side effect.
    - In all cases, go to S_CMD.
  - S_SKIP:
    - drv_data_in = 0.
    - On frame_end, go to S_CMD without touching the bank.
- Timeout:
  - Counter is cleared on entry to S_DATA/S_SKIP.
  - It increments each clk while in S_DATA/S_SKIP and drv_ready=1.
  - It freezes while drv_ready=0 (frame in progress).
  - When the count reaches TIMEOUT_CYCLES: set err, go to S_CMD.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Frame timing:
  - The master must keep cs high at least 4 clk between frames.
  - The controller updates drv_data_in within 2 clk of drv_ready rising.
  - Updating drv_data_in at any time while drv_ready=1 is legal; the shifter samples it only at frame start.
- Frame start in S_CMD needs no action.
- A frame_end coinciding with timeout expiry: frame_end has priority and the byte is processed normally.
- err set and clear in the same cycle: set wins.
- Reset values, all taken immediately on reset:
  - state S_CMD, all registers 0, regs_flat 0.
  - wr_strobe 0, wr_addr 0, err 0.
  - drv_data_in = {0, 8'h25}, ready_q 1, timeout counter 0.
- Reset mid-frame: controller returns to S_CMD. The partially received frame is ignored unless drv_ready later rises; in that case it is treated as a command byte.

Test Plan:
- Write then read back:
  - Frames 0x83, 0x5C -> wr_strobe pulse, wr_addr=3, regs_flat[31:24]=0x5C.
  - Frames 0x03, xx -> master shifts in 0x5C on the second frame.
- Status read:
  - ro_status=0xA7; frames 0x00, xx -> master receives 0xA7.
  - err stays 0; the first frame returns 0x25.
- Reserved-bit error:
  - Frames 0x90, 0xFF -> err=1, no wr_strobe, bank unchanged.
  - Next command frame returns 0xA5.
  - Read of address 0 then clears err.
- Write to address 0:
  - Frames 0x80, 0x11 -> err=1, no wr_strobe, regs_flat[7:0] stays 0.
- Timeout:
  - TIMEOUT_CYCLES=20; frame 0x85, then cs held high 25 clk -> err=1 at cycle 20, state S_CMD.
  - Next frame 0x12 is treated as a command.
- Async reset:
  - Assert rst mid-data-frame after writes to regs 1 and 2 -> all outputs take reset values immediately.
  - A following 0x81, 0x33 sequence works normally.
